// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate at tail, mark done by index, retire from head.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module reorder_buffer #(
  parameter int ROB_SIZE      = 16,
  parameter int ROB_SIZE_LOG2 = 4,
  parameter int ISSUE_PORTS   = 2,
  parameter int PREG_W        = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alloc_valid,
  input  logic [4:0]                           alloc_ard,
  input  logic [PREG_W-1:0]                    alloc_prd,
  input  logic [PREG_W-1:0]                    alloc_old_prd,
  input  logic                                 alloc_has_dest,
  output logic                                 alloc_ready,
  output logic [ROB_SIZE_LOG2-1:0]             rob_index,
  input  logic [ISSUE_PORTS-1:0]               cmpl_valid,
  input  logic [ISSUE_PORTS*ROB_SIZE_LOG2-1:0] cmpl_index,
  output logic                                 commit_valid,
  input  logic                                 commit_ready,
  output logic [4:0]                           commit_ard,
  output logic [PREG_W-1:0]                    commit_prd,
  output logic [PREG_W-1:0]                    commit_old_prd,
  output logic                                 commit_has_dest,
  output logic [ROB_SIZE_LOG2:0]               count
);

  localparam int L = ROB_SIZE_LOG2;
  localparam logic [L:0] PTR_ONE = (L+1)'(1);

  logic [L:0]          head, tail;
  logic [ROB_SIZE-1:0] valid_q, done_q;
  logic [4:0]          ard_q     [ROB_SIZE];
  logic [PREG_W-1:0]   prd_q     [ROB_SIZE];
  logic [PREG_W-1:0]   old_prd_q [ROB_SIZE];
  logic [ROB_SIZE-1:0] has_dest_q;

  logic [L-1:0] head_idx, tail_idx;
  logic         full, alloc_fire, commit_fire;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid and the payload stay stable while ready is low, ready never depends on valid.
  assign head_idx    = head[L-1:0];
  assign tail_idx    = tail[L-1:0];
  assign full        = (head_idx == tail_idx) && (head[L] != tail[L]);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign rob_index   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign commit_valid    = valid_q[head_idx] && done_q[head_idx];
  assign commit_ard      = ard_q[head_idx];
  assign commit_prd      = prd_q[head_idx];
  assign commit_old_prd  = old_prd_q[head_idx];
  assign commit_has_dest = has_dest_q[head_idx];
  assign commit_fire     = commit_valid && commit_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      has_dest_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        ard_q[i]     <= '0;
        prd_q[i]     <= '0;
        old_prd_q[i] <= '0;
      end
    end else begin
      // Completions only mark live entries; stale or early indices are dropped.
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (cmpl_valid[p] && valid_q[cmpl_index[p*L +: L]])
          done_q[cmpl_index[p*L +: L]] <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_idx]    <= 1'b1;
        done_q[tail_idx]     <= 1'b0;
        ard_q[tail_idx]      <= alloc_ard;
        prd_q[tail_idx]      <= alloc_prd;
        old_prd_q[tail_idx]  <= alloc_old_prd;
        has_dest_q[tail_idx] <= alloc_has_dest;
        tail                 <= tail + PTR_ONE;
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head              <= head + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation order, completion, in-order retirement,
// full/wrap boundaries, duplicate and stray completions, commit stall and mid-run reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_ard;
  logic [5:0]  alloc_prd;
  logic [5:0]  alloc_old_prd;
  logic        alloc_has_dest;
  logic        alloc_ready;
  logic [3:0]  rob_index;
  logic [1:0]  cmpl_valid;
  logic [7:0]  cmpl_index;
  logic        commit_valid;
  logic        commit_ready;
  logic [4:0]  commit_ard;
  logic [5:0]  commit_prd;
  logic [5:0]  commit_old_prd;
  logic        commit_has_dest;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_ard;
  logic [3:0] exp_idx;
  logic [3:0] prev_idx;
  logic       have_prev;
  int         n_commits;

  reorder_buffer #(.ROB_SIZE(16), .ROB_SIZE_LOG2(4), .ISSUE_PORTS(2), .PREG_W(6)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ard(alloc_ard), .alloc_prd(alloc_prd),
    .alloc_old_prd(alloc_old_prd), .alloc_has_dest(alloc_has_dest),
    .alloc_ready(alloc_ready), .rob_index(rob_index),
    .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_ard(commit_ard), .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .commit_has_dest(commit_has_dest), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] ard, input logic [5:0] prd, input logic [5:0] old_prd);
    alloc_valid    = 1'b1;
    alloc_ard      = ard;
    alloc_prd      = prd;
    alloc_old_prd  = old_prd;
    alloc_has_dest = 1'b1;
    tick();
    alloc_valid    = 1'b0;
  endtask

  task automatic complete(input logic [3:0] idx);
    cmpl_valid = 2'b01;
    cmpl_index = {4'd0, idx};
    tick();
    cmpl_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; alloc_valid = 1'b0; alloc_ard = '0; alloc_prd = '0; alloc_old_prd = '0;
    alloc_has_dest = 1'b0; cmpl_valid = '0; cmpl_index = '0; commit_ready = 1'b0;
    do_reset();
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_rob_index", rob_index, 0);
    check("rst_count", count, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_ard", commit_ard, 0);
    check("rst_commit_prd", commit_prd, 0);

    // Three allocations take indices 0,1,2
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_ard = 5'(i + 1); alloc_prd = 6'(33 + i);
      alloc_old_prd = 6'(10 + i); alloc_has_dest = 1'b1;
      #1;
      check("t1_rob_index", rob_index, i);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("t1_count", count, 3);
    check("t1_commit_valid", commit_valid, 0);

    // Out-of-order completion, in-order retirement
    complete(4'd1);
    #1;
    check("t2_no_commit_idx1", commit_valid, 0);
    cmpl_valid = 2'b01; cmpl_index = 8'd0;
    #1;
    check("t2_no_bypass", commit_valid, 0);
    tick();
    cmpl_valid = 2'b00;
    #1;
    check("t2_commit_valid0", commit_valid, 1);
    check("t2_commit_ard0", commit_ard, 1);
    check("t2_commit_prd0", commit_prd, 33);
    check("t2_commit_old0", commit_old_prd, 10);
    check("t2_commit_hd0", commit_has_dest, 1);
    commit_ready = 1'b1;
    tick();
    check("t2_commit_valid1", commit_valid, 1);
    check("t2_commit_ard1", commit_ard, 2);
    tick();
    check("t2_head_stall", commit_valid, 0);
    check("t2_count", count, 1);
    commit_ready = 1'b0;
    complete(4'd2);
    commit_ready = 1'b1;
    tick();
    commit_ready = 1'b0;
    #1;
    check("t2_drained", count, 0);

    // Fill all 16 entries starting at index 3
    for (int k = 0; k < 16; k++) begin
      alloc(5'(k), 6'(k), 6'(k));
      exp_q.push_back(5'(k));
    end
    #1;
    check("t3_full_ready", alloc_ready, 0);
    check("t3_full_count", count, 16);
    complete(4'd3);
    alloc_valid = 1'b1; alloc_ard = 5'd31; commit_ready = 1'b1;
    #1;
    check("t3_full_refuse", alloc_ready, 0);
    check("t3_commit_valid", commit_valid, 1);
    exp_ard = exp_q.pop_front();
    check("t3_commit_ard", commit_ard, exp_ard);
    tick();
    alloc_valid = 1'b0; commit_ready = 1'b0;
    #1;
    check("t3_count_15", count, 15);
    check("t3_ready_again", alloc_ready, 1);
    check("t3_tail_held", rob_index, 3);
    for (int j = 1; j < 16; j++) complete(4'((3 + j) % 16));
    commit_ready = 1'b1;
    for (int j = 0; j < 15; j++) begin
      #1;
      check("t3_drain_valid", commit_valid, 1);
      exp_ard = exp_q.pop_front();
      check("t3_drain_ard", commit_ard, exp_ard);
      tick();
    end
    commit_ready = 1'b0;
    #1;
    check("t3_empty", count, 0);

    // Streaming alloc/complete/commit across the index wrap
    exp_idx = 4'd3; have_prev = 1'b0; prev_idx = '0; n_commits = 0;
    commit_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      alloc_valid = (i < 20); alloc_ard = 5'((i + 5) % 32);
      alloc_prd = 6'(i); alloc_old_prd = 6'(i); alloc_has_dest = 1'b0;
      cmpl_valid = {1'b0, have_prev}; cmpl_index = {4'd0, prev_idx};
      #1;
      if (alloc_valid) begin
        check("t4_rob_index", rob_index, exp_idx);
        exp_q.push_back(alloc_ard);
      end
      if (commit_valid) begin
        exp_ard = exp_q.pop_front();
        check("t4_commit_ard", commit_ard, exp_ard);
        n_commits++;
      end
      have_prev = alloc_valid;
      prev_idx  = exp_idx;
      if (alloc_valid) exp_idx = exp_idx + 4'd1;
      tick();
    end
    alloc_valid = 1'b0; cmpl_valid = 2'b00; commit_ready = 1'b0;
    #1;
    check("t4_commits", n_commits, 20);
    check("t4_count", count, 0);

    // Duplicate completion of idx 4 and stray completion of unallocated idx 9
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc(5'(20 + i), 6'(i), 6'(i));
      exp_q.push_back(5'(20 + i));
    end
    cmpl_valid = 2'b11; cmpl_index = {4'd4, 4'd4};
    tick();
    cmpl_valid = 2'b01; cmpl_index = {4'd0, 4'd9};
    tick();
    cmpl_valid = 2'b00;
    #1;
    check("t5_head_not_done", commit_valid, 0);
    check("t5_count", count, 5);
    for (int i = 0; i < 4; i++) complete(4'(i));
    commit_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("t5_commit_valid", commit_valid, 1);
      exp_ard = exp_q.pop_front();
      check("t5_commit_ard", commit_ard, exp_ard);
      tick();
    end
    commit_ready = 1'b0;
    #1;
    check("t5_drained", count, 0);
    check("t5_no_extra", commit_valid, 0);
    for (int i = 0; i < 5; i++) alloc(5'(10 + i), 6'(i), 6'(i));
    for (int i = 5; i < 9; i++) complete(4'(i));
    commit_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("t5_second_ard", commit_ard, 10 + j);
      tick();
    end
    commit_ready = 1'b0;
    #1;
    check("t5_idx9_not_done", commit_valid, 0);
    check("t5_idx9_ard", commit_ard, 14);
    check("t5_count_1", count, 1);

    // Commit stall holds the head; reset mid-run discards everything
    complete(4'd9);
    #1;
    check("t6_valid", commit_valid, 1);
    tick();
    tick();
    check("t6_held_valid", commit_valid, 1);
    check("t6_held_ard", commit_ard, 14);
    check("t6_held_count", count, 1);
    alloc(5'd7, 6'd7, 6'd7);
    alloc(5'd8, 6'd8, 6'd8);
    rst = 1'b1; alloc_valid = 1'b1; cmpl_valid = 2'b01; cmpl_index = {4'd0, 4'd10};
    tick();
    rst = 1'b0; alloc_valid = 1'b0; cmpl_valid = 2'b00;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_commit_valid", commit_valid, 0);
    check("t6_rst_alloc_ready", alloc_ready, 1);
    check("t6_rst_rob_index", rob_index, 0);
    check("t6_rst_commit_ard", commit_ard, 0);
    check("t6_rst_commit_prd", commit_prd, 0);
    complete(4'd0);
    #1;
    check("t6_stray_after_rst", commit_valid, 0);
    alloc(5'd3, 6'd3, 6'd3);
    #1;
    check("t6_fresh_not_done", commit_valid, 0);
    check("t6_fresh_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
